restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001: The module SHALL have parameter DVD_W, default 8, dividend and quotient width.
REQ-002: The module SHALL have parameter DVS_W, default 4, divisor and remainder width.
REQ-003: The module SHALL run from one clock and SHALL use an asynchronous, active-low reset.
REQ-004: Port clk  input  1  rising-edge clock for all state.
REQ-005: Port rst_n  input  1  asynchronous active-low reset.
REQ-006: Port in_valid  input  1  operand pair presented.
REQ-007: Port in_ready  output  1  divider can accept operands.
REQ-008: Port dividend  input  DVD_W  unsigned dividend.
REQ-009: Port divisor  input  DVS_W  unsigned divisor.
REQ-010: Port out_valid  output  1  result available.
REQ-011: Port out_ready  input  1  consumer accepts result.
REQ-012: Port quotient  output  DVD_W  unsigned quotient.
REQ-013: Port remainder  output  DVS_W  unsigned remainder.
REQ-014: Port div_by_zero  output  1  result came from a zero divisor.

Function
REQ-015: States SHALL be IDLE, CALC and DONE.
REQ-016: in_ready SHALL be 1 only in IDLE.
REQ-017: out_valid SHALL be 1 only in DONE.
REQ-018: Accept SHALL occur on a rising edge with in_valid=1 in IDLE; operands SHALL be captured on that edge.
REQ-019: On accept with divisor!=0, the next state SHALL be CALC, the iteration counter SHALL be 0 and the partial remainder (DVS_W+1 bits) SHALL be 0.
REQ-020: Each CALC edge SHALL perform one restoring step, MSB of the dividend first: shift the dividend MSB into the partial remainder, then trial-subtract the divisor. If the result is non-negative, keep the difference and set quotient bit 1; otherwise restore the remainder and set quotient bit 0.
REQ-021: After exactly DVD_W CALC edges the state SHALL be DONE, so out_valid rises DVD_W cycles after the accept edge (8 for defaults).
REQ-022: On accept with divisor==0, the next state SHALL be DONE directly (latency 1). Outputs SHALL be quotient=all ones, remainder=all ones, div_by_zero=1.
REQ-023: For divisor!=0, outputs SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, and div_by_zero SHALL be 0.
REQ-024: In DONE, quotient, remainder and div_by_zero SHALL hold stable while out_ready=0.
REQ-025: A DONE edge with out_ready=1 SHALL return the state to IDLE; out_valid SHALL drop on that edge.
REQ-026: Results are not back-to-back; a new accept SHALL occur no earlier than the edge after return to IDLE.
REQ-027: in_valid and operand changes outside IDLE SHALL be ignored.
REQ-028: quotient, remainder and div_by_zero SHALL be registered and unchanged outside DONE until the next result is written.

Reset
REQ-029: rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0 and counter=0, independent of clk.
REQ-030: Reset asserted during CALC or DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-031: After rst_n deasserts, the first rising edge with in_valid=1 SHALL be a legal accept.

Structure
REQ-032: A shared package div_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the default width constants DVD_W_DEF=8 and DVS_W_DEF=4.
REQ-033: The restoring step SHALL be a combinational sub-module div_step: inputs are partial remainder, next dividend bit and divisor; outputs are the new partial remainder and the quotient bit.
REQ-034: The counter width SHALL be $clog2(DVD_W+1).

Verification
REQ-035: Accept 200/7 -> out_valid 8 cycles after accept; quotient=28, remainder=4, div_by_zero=0.
REQ-036: Accept 255/1 -> quotient=255, remainder=0; then 5/9 -> quotient=0, remainder=5.
REQ-037: Accept 13/0 -> out_valid 1 cycle after accept; quotient=8'hFF, remainder=4'hF, div_by_zero=1.
REQ-038: Accept 100/3 with out_ready=0 for 5 cycles after out_valid -> outputs hold 33/1 throughout, in_ready=0, and a new in_valid is ignored; release out_ready -> IDLE next edge.
REQ-039: Assert rst_n=0 at the 4th CALC cycle of 77/5 -> all outputs at reset values immediately; after release, accept 77/5 -> quotient=15, remainder=2.
REQ-040: Exhaustive sweep of all 256x16 operand pairs with random out_ready backpressure -> every result matches a reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default widths.
package div_pkg;

   localparam int DVD_W_DEF = 8;
   localparam int DVS_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int DVS_W = div_pkg::DVS_W_DEF
) (
   input  logic [DVS_W:0]   rem_in,
   input  logic             dvd_bit,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVS_W:0]   rem_out,
   output logic             q_bit
);

   logic [DVS_W:0]   shifted;
   logic [DVS_W+1:0] trial;

   // rem_in is always below the divisor, so its top bit is zero and dropping it loses nothing.
   assign shifted = {rem_in[DVS_W-1:0], dvd_bit};
   assign trial   = {1'b0, shifted} - {2'b00, divisor};
   assign q_bit   = ~trial[DVS_W+1];
   assign rem_out = q_bit ? trial[DVS_W:0] : shifted;

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
module restoring_divider
   import div_pkg::*;
#(
   parameter int DVD_W = DVD_W_DEF,
   parameter int DVS_W = DVS_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // in_ready is high only in IDLE and out_valid only in DONE, so they never overlap.

   localparam int                 CNT_W = $clog2(DVD_W + 1);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DVD_W - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [DVD_W-1:0] work;
   logic [DVS_W-1:0] dvs_q;
   logic [DVS_W:0]   prem;
   logic [DVS_W:0]   step_rem;
   logic             step_q;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;

   // work holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
   div_step #(.DVS_W(DVS_W)) u_step (
      .rem_in  (prem),
      .dvd_bit (work[DVD_W-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         work        <= '0;
         dvs_q       <= '0;
         prem        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                     cnt   <= '0;
                     prem  <= '0;
                     work  <= dividend;
                     dvs_q <= divisor;
                  end
               end
            end
            CALC: begin
               prem <= step_rem;
               work <= {work[DVD_W-2:0], step_q};
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state       <= DONE;
                  quotient    <= {work[DVD_W-2:0], step_q};
                  remainder   <= step_rem[DVS_W-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases, reset abort and a full operand sweep.
module tb_restoring_divider;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   // Expected result packed as {div_by_zero, quotient, remainder}.
   logic [12:0] exp_q[$];

   restoring_divider #(.DVD_W(8), .DVS_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] ref_div(input logic [7:0] a, input logic [3:0] b);
      if (b == 4'd0) return {1'b1, 8'hFF, 4'hF};
      return {1'b0, 8'(a / b), 4'(a % b)};
   endfunction

   // Driver: present one operation, wait for its result, apply bp cycles of backpressure, retire it.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int bp, input bit hold_chk);
      int lat;
      logic [12:0] exp;
      @(negedge clk);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(ref_div(a, b));
      #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 40);
      check("latency", 32'(lat), (b == 4'd0) ? 32'd1 : 32'd8);
      exp = exp_q[0];
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (hold_chk) begin
            in_valid = 1'b1;
            dividend = 8'd250;
            divisor  = 4'd2;
            check("hold_result", {19'd0, div_by_zero, quotient, remainder}, {19'd0, exp});
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("out_valid_at_retire", 32'(out_valid), 32'd1);
      exp = exp_q.pop_front();
      check("result", {19'd0, div_by_zero, quotient, remainder}, {19'd0, exp});
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_retire", 32'(out_valid), 32'd0);
      check("in_ready_after_retire", 32'(in_ready), 32'd1);
      check("result_kept_in_idle", {19'd0, div_by_zero, quotient, remainder}, {19'd0, exp});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outputs", {19'd0, div_by_zero, quotient, remainder}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'd200, 4'd7, 0, 1'b0);
      run_op(8'd255, 4'd1, 1, 1'b0);
      run_op(8'd5,   4'd9, 0, 1'b0);
      run_op(8'd13,  4'd0, 2, 1'b0);
      run_op(8'd100, 4'd3, 5, 1'b1);

      // Reset during the fourth CALC cycle must clear everything without a clock edge.
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'd77;
      divisor  = 4'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("calc_before_abort", 32'(dbg_state), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_outputs", {19'd0, div_by_zero, quotient, remainder}, 32'd0);
      check("abort_state", 32'(dbg_state), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_valid_after_abort", 32'(out_valid), 32'd0);
      end
      run_op(8'd77, 4'd5, 0, 1'b0);

      // Full operand sweep with random backpressure.
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            int bp;
            bp = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            run_op(8'(a), 4'(b), bp, 1'b0);
         end
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
